// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-N counter.
// FSM state encoding and the wrap counter width live here.
package counter_pkg;

    localparam int unsigned WRAP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_mod_step.sv
// Combinational datapath for counter_mod_n: initial value, next step with wrap,
// terminal detection and load clamping. Holds no state.
module counter_mod_step #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_step,
    output logic [WIDTH-1:0] q_init,
    output logic [WIDTH-1:0] load_clamped,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] term_val;

    assign term_val = up ? MAX_VAL : '0;
    assign at_term  = (q == term_val);
    assign q_init   = up ? '0 : MAX_VAL;

    // Wrapping step; the terminal value jumps to the opposite end of the range
    always_comb begin
        q_step = q;
        if (up) begin
            q_step = at_term ? '0 : q + WIDTH'(1);
        end else begin
            q_step = at_term ? MAX_VAL : q - WIDTH'(1);
        end
    end

    // Extended compare so MODULO == 2**WIDTH needs no special case
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

endmodule

// File: rtl/counter_mod_n.sv
// Up/down modulo-N counter with IDLE/RUN/DONE control, one-shot or free-run.
// Optional wrap counter enabled by defining COUNTER_WRAPCNT_EN.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 16
) (
    input  logic                  clki,
    input  logic                  rs,
    input  logic                  en,
    input  logic                  up,
    input  logic                  start,
    input  logic                  oneshot,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  busy,
    output logic                  done,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_init;
    logic [WIDTH-1:0] load_clamped;
    logic             at_term;

    counter_mod_step #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_step (
        .q            (q),
        .up           (up),
        .load_val     (load_val),
        .q_step       (q_step),
        .q_init       (q_init),
        .load_clamped (load_clamped),
        .at_term      (at_term)
    );

    always_ff @(posedge clki) begin
        if (rs) begin
            state <= IDLE;
            q     <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
        end
    end

    // Priority load > start > count; load never moves the FSM
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        if (load) begin
            q_nxt = load_clamped;
        end else if (start) begin
            q_nxt     = q_init;
            state_nxt = RUN;
        end else if ((state == RUN) && en) begin
            if (at_term && oneshot) begin
                state_nxt = DONE;
            end else begin
                q_nxt = q_step;
            end
        end
    end

    assign tc   = ~rs & (state == RUN) & en & at_term;
    assign busy = ~rs & (state == RUN);
    assign done = ~rs & (state == DONE);

`ifdef COUNTER_WRAPCNT_EN
    logic                  wrap_evt;
    logic [WRAP_CNT_W-1:0] wrap_q;

    assign wrap_evt = (state == RUN) & en & ~load & ~start & at_term & ~oneshot;

    // Saturating count of free-run wraps, cleared only by reset
    always_ff @(posedge clki) begin
        if (rs) begin
            wrap_q <= '0;
        end else if (wrap_evt && (wrap_q != '1)) begin
            wrap_q <= wrap_q + WRAP_CNT_W'(1);
        end
    end

    assign wrap_cnt = wrap_q;
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed self-checking bench for counter_mod_n at WIDTH=4, MODULO=10.
module tb_counter_mod_n;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned MODULO = 10;

    logic             clki = 1'b0;
    logic             rs, en, up, start, oneshot, load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc, busy, done;
    logic [7:0]       wrap_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_wrap;

    counter_mod_n #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .clki     (clki),
        .rs       (rs),
        .en       (en),
        .up       (up),
        .start    (start),
        .oneshot  (oneshot),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clki = ~clki;

    task automatic tick();
        @(posedge clki);
        #2;
    endtask

    task automatic test_reset();
        rs = 1'b1; en = 1'b1; up = 1'b1; start = 1'b1; oneshot = 1'b0;
        load = 1'b0; load_val = '0;
        tick();
        tick();
        checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
        checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL reset_wrap got=%0d exp=0", wrap_cnt); end
        rs = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || q !== 4'd0) begin failures++; $display("FAIL idle_hold q=%0d busy=%b exp q=0 busy=0", q, busy); end
    endtask

    task automatic test_free_run_up();
        logic [3:0] exp_q;
        up = 1'b1; oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            exp_q = 4'(i % 10);
            checks++; if (q !== exp_q) begin failures++; $display("FAIL fr_up_q[%0d] got=%0d exp=%0d", i, q, exp_q); end
            checks++; if (tc !== (exp_q == 4'd9)) begin failures++; $display("FAIL fr_up_tc[%0d] got=%b exp=%b", i, tc, exp_q == 4'd9); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fr_up_busy[%0d] got=%b exp=1", i, busy); end
            tick();
        end
`ifdef COUNTER_WRAPCNT_EN
        exp_wrap = 8'd1;
`else
        exp_wrap = 8'd0;
`endif
        checks++; if (wrap_cnt !== exp_wrap) begin failures++; $display("FAIL fr_up_wrap got=%0d exp=%0d", wrap_cnt, exp_wrap); end
    endtask

    task automatic test_oneshot_down();
        logic [3:0] exp_q;
        up = 1'b0; oneshot = 1'b1; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            exp_q = 4'(9 - i);
            checks++; if (q !== exp_q) begin failures++; $display("FAIL os_dn_q[%0d] got=%0d exp=%0d", i, q, exp_q); end
            checks++; if (tc !== (i == 9)) begin failures++; $display("FAIL os_dn_tc[%0d] got=%b exp=%b", i, tc, i == 9); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (q !== 4'd0) begin failures++; $display("FAIL os_hold_q[%0d] got=%0d exp=0", i, q); end
            checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL os_done[%0d] done=%b busy=%b exp done=1 busy=0", i, done, busy); end
            checks++; if (tc !== 1'b0) begin failures++; $display("FAIL os_tc_done[%0d] got=%b exp=0", i, tc); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 4'd9) begin failures++; $display("FAIL os_restart_q got=%0d exp=9", q); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL os_restart_st busy=%b done=%b exp busy=1 done=0", busy, done); end
    endtask

    task automatic test_load_clamp();
        logic [3:0] vals [4] = '{4'd13, 4'd10, 4'd15, 4'd9};
        logic [3:0] exps [4] = '{4'd9,  4'd9,  4'd9,  4'd9};
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; load_val = 4'd2;
            tick();
            load_val = vals[i];
            tick();
            load = 1'b0;
            checks++; if (q !== exps[i]) begin failures++; $display("FAIL clamp[%0d] load=%0d got=%0d exp=%0d", i, vals[i], q, exps[i]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clamp_state[%0d] busy=%b exp=1", i, busy); end
        end
        rs = 1'b1;
        tick();
        rs = 1'b0;
        up = 1'b1; load = 1'b1; start = 1'b1; load_val = 4'd4;
        tick();
        load = 1'b0; start = 1'b0;
        checks++; if (q !== 4'd4) begin failures++; $display("FAIL load_start_q got=%0d exp=4", q); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL load_start_st busy=%b done=%b exp 0 0", busy, done); end
        en = 1'b1;
        tick();
        tick();
        checks++; if (q !== 4'd4) begin failures++; $display("FAIL idle_no_count got=%0d exp=4", q); end
    endtask

    task automatic test_reset_mid_run();
        up = 1'b1; oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (q !== 4'd6 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre q=%0d busy=%b exp q=6 busy=1", q, busy); end
        rs = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL in_reset busy=%b tc=%b done=%b exp 0 0 0", busy, tc, done); end
        tick();
        rs = 1'b0;
        checks++; if (q !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst q=%0d busy=%b exp q=0 busy=0", q, busy); end
        checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_wrap got=%0d exp=0", wrap_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== 4'd0) begin failures++; $display("FAIL post_rst_hold[%0d] got=%0d exp=0", i, q); end
        end
    endtask

    task automatic test_en_dir();
        logic [3:0] exp_dn [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        up = 1'b1; oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (q !== 4'd3) begin failures++; $display("FAIL en_pre got=%0d exp=3", q); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== 4'd3) begin failures++; $display("FAIL en_gate[%0d] got=%0d exp=3", i, q); end
            checks++; if (tc !== 1'b0) begin failures++; $display("FAIL en_gate_tc[%0d] got=%b exp=0", i, tc); end
        end
        en = 1'b1; up = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (q !== exp_dn[i]) begin failures++; $display("FAIL dir_dn[%0d] got=%0d exp=%0d", i, q, exp_dn[i]); end
            checks++; if (tc !== (exp_dn[i] == 4'd0)) begin failures++; $display("FAIL dir_dn_tc[%0d] got=%b exp=%b", i, tc, exp_dn[i] == 4'd0); end
            tick();
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dn_wrap_busy got=%b exp=1", busy); end
`ifdef COUNTER_WRAPCNT_EN
        exp_wrap = 8'd1;
`else
        exp_wrap = 8'd0;
`endif
        checks++; if (wrap_cnt !== exp_wrap) begin failures++; $display("FAIL dn_wrap_cnt got=%0d exp=%0d", wrap_cnt, exp_wrap); end
    endtask

    initial begin
        test_reset();
        test_free_run_up();
        test_oneshot_down();
        test_load_clamp();
        test_reset_mid_run();
        test_en_dir();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
